// File: rtl/dac_serializador_if.sv
// Sample-in / DAC-pin-out bundle of the DAC serializer. The filter side drives Yk and Bandera_Listo.
// The serializer (slave) drives the SPI-style DAC pins and the status flags.
interface dac_serializador_if #(
  parameter int N = 25
);
  logic [N-1:0] Yk;
  logic         Bandera_Listo;
  logic         DAC_SYNC_n;
  logic         DAC_SCLK;
  logic         DAC_DIN;
  logic         Ocupado;
  logic         Bandera_DAC;
  logic         Sobre_Escritura;

  modport master (
    output Yk, Bandera_Listo,
    input  DAC_SYNC_n, DAC_SCLK, DAC_DIN, Ocupado, Bandera_DAC, Sobre_Escritura
  );

  modport slave (
    input  Yk, Bandera_Listo,
    output DAC_SYNC_n, DAC_SCLK, DAC_DIN, Ocupado, Bandera_DAC, Sobre_Escritura
  );
endinterface

// File: rtl/dac_serializador.sv
// Saturates filter samples to 12 bits and shifts them out as 16-bit DAC frames, MSB first, 32*DIV Clk per frame.
// The frame starts 1 Clk after capture. There is no backpressure: a one-deep pending slot where the newest sample wins, and Sobre_Escritura flags each dropped sample.
module dac_serializador #(
  parameter int N     = 25,
  parameter int SHIFT = 8,
  parameter int DIV   = 2
) (
  input logic               Clk,
  input logic               Reset_n,
  dac_serializador_if.slave bus
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic signed [N+12:0] CODE_MAX = 4095;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t          state_q, state_nxt;
  logic [DW-1:0]   dcnt_q;
  logic [4:0]      hcnt_q;
  logic [15:0]     sreg_q;
  logic [11:0]     pend_q;
  logic            pend_v_q;
  logic            ow_q;
  logic            tick;
  logic            consume;
  logic signed [N+12:0] ext;
  logic [11:0]     code;

  // The sign-extended word leaves headroom for the saturation compare.
  always_comb begin
    ext = $signed({{13{bus.Yk[N-1]}}, bus.Yk}) >>> SHIFT;
    if (ext[N+12])
      code = 12'h000;
    else if (ext > CODE_MAX)
      code = 12'hFFF;
    else
      code = ext[11:0];
  end

  assign tick    = (dcnt_q == DW'(DIV - 1));
  assign consume = (state_q == ST_IDLE) && pend_v_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q != state_nxt) begin
        dcnt_q <= '0;
        hcnt_q <= '0;
      end else if (tick) begin
        dcnt_q <= '0;
        hcnt_q <= hcnt_q + 5'd1;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
      // The next bit is presented on each SCLK rise (odd half-period boundary).
      if (consume)
        sreg_q <= {4'b0000, pend_q};
      else if ((state_q == ST_SHIFT) && tick && hcnt_q[0])
        sreg_q <= {sreg_q[14:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (pend_v_q) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tick && (hcnt_q == 5'd31)) state_nxt = ST_GAP;
      ST_GAP:   if (tick && (hcnt_q == 5'd1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.DAC_SYNC_n  = 1'b1;
    bus.DAC_SCLK    = 1'b1;
    bus.DAC_DIN     = 1'b0;
    bus.Bandera_DAC = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        bus.DAC_SYNC_n = 1'b0;
        bus.DAC_SCLK   = ~hcnt_q[0];
        bus.DAC_DIN    = sreg_q[15];
      end
      ST_GAP:   bus.Bandera_DAC = (hcnt_q == 5'd0) && (dcnt_q == '0);
      default:  ;
    endcase
  end

  // A strobe on the consume edge refills the slot without counting as an overwrite.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ow_q     <= 1'b0;
    end else begin
      ow_q <= bus.Bandera_Listo && pend_v_q && !consume;
      if (bus.Bandera_Listo) begin
        pend_q   <= code;
        pend_v_q <= 1'b1;
      end else if (consume) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign bus.Ocupado         = (state_q != ST_IDLE) || pend_v_q;
  assign bus.Sobre_Escritura = ow_q;
endmodule

// File: tb/tb_dac_serializador.sv
// Bench for dac_serializador. A timing-arithmetic reference model predicts frames, overwrites and busy.
// A pin-level monitor decodes frames and checks the DAC timing rules.
module tb_dac_serializador;
  localparam int N     = 25;
  localparam int SHIFT = 8;
  localparam int DIV   = 2;

  logic Clk = 1'b0;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;

  dac_serializador_if #(.N(N)) bus();

  dac_serializador #(.N(N), .SHIFT(SHIFT), .DIV(DIV)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frames are scheduled from the DAC timing rules.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  longint      cyc = 0;
  longint      m_free_at = 0;
  logic        m_pend_v = 1'b0;
  logic [11:0] m_pend_code = '0;
  logic        m_ow = 1'b0;
  logic        m_ocup = 1'b0;
  int          m_ow_cnt = 0;
  int          dut_ow_cnt = 0;

  function automatic logic [11:0] ref_code(input logic [N-1:0] y);
    longint v;
    v = longint'($signed(y));
    v = v >>> SHIFT;
    if (v < 0) return 12'h000;
    if (v > 4095) return 12'hFFF;
    return 12'(v);
  endfunction

  task automatic model_edge(input logic s, input logic [N-1:0] y);
    logic load;
    load = m_pend_v && (cyc >= m_free_at);
    m_ow = s && m_pend_v && !load;
    if (load) begin
      exp_q.push_back({4'h0, m_pend_code});
      m_free_at = cyc + 34 * DIV + 1;
      m_pend_v  = 1'b0;
    end
    if (s) begin
      m_pend_code = ref_code(y);
      m_pend_v    = 1'b1;
    end
    m_ocup = (cyc < m_free_at - 1) || m_pend_v;
    if (m_ow) m_ow_cnt++;
    cyc++;
  endtask

  task automatic step(input logic s, input logic [N-1:0] y);
    @(negedge Clk);
    bus.Bandera_Listo = s;
    bus.Yk = y;
    @(posedge Clk);
    model_edge(s, y);
    #1;
    chk("sobre_escritura", bus.Sobre_Escritura, m_ow);
    chk("ocupado", bus.Ocupado, m_ocup);
    if (bus.Sobre_Escritura) dut_ow_cnt++;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      step(1'b0, '0);
      n++;
    end while (bus.Ocupado && n < bound);
    chk("idle_timeout", bus.Ocupado, 1'b0);
  endtask

  task automatic check_frames();
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk("frame_vs_model", got_q.pop_front(), exp_q.pop_front());
    chk("frames_left", got_q.size(), exp_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sync_n"}, bus.DAC_SYNC_n, 1'b1);
    chk({tag, "_sclk"}, bus.DAC_SCLK, 1'b1);
    chk({tag, "_din"}, bus.DAC_DIN, 1'b0);
    chk({tag, "_ocupado"}, bus.Ocupado, 1'b0);
    chk({tag, "_bandera_dac"}, bus.Bandera_DAC, 1'b0);
    chk({tag, "_sobre"}, bus.Sobre_Escritura, 1'b0);
  endtask

  // Pin monitor: decodes frames, checks DIN stability at SCLK falls, frame length and SYNC gap.
  logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;
  logic        in_frame = 1'b0, fr_end;
  int          nfalls = 0, low_cnt = 0, high_cnt = 1000, n_band = 0;
  logic [15:0] bits = '0;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      in_frame = 1'b0; prev_sync = 1'b1; prev_sclk = 1'b1; prev_din = 1'b0; high_cnt = 1000;
    end else begin
      fr_end = 1'b0;
      if (prev_sync && !bus.DAC_SYNC_n) begin
        checks++;
        if (high_cnt < 2 * DIV) begin
          errors++;
          $display("FAIL sync_gap: high %0d cycles, need at least %0d", high_cnt, 2 * DIV);
        end
        in_frame = 1'b1; nfalls = 0; low_cnt = 0; bits = '0;
      end
      if (in_frame && !bus.DAC_SYNC_n) begin
        low_cnt++;
        if (prev_sclk && !bus.DAC_SCLK) begin
          chk("din_stable_at_fall", bus.DAC_DIN, prev_din);
          nfalls++;
          bits = {bits[14:0], bus.DAC_DIN};
        end
      end
      if (in_frame && bus.DAC_SYNC_n) begin
        fr_end = 1'b1; in_frame = 1'b0; high_cnt = 0;
        chk("mon_falls", nfalls, 16);
        chk("mon_frame_len", low_cnt, 32 * DIV);
        chk("mon_bandera_at_end", bus.Bandera_DAC, 1'b1);
        got_q.push_back(bits);
      end
      if (bus.Bandera_DAC) begin
        n_band++;
        if (!fr_end) chk("bandera_outside_frame_end", fr_end, 1'b1);
      end
      if (bus.DAC_SYNC_n) high_cnt++;
      prev_sync = bus.DAC_SYNC_n; prev_sclk = bus.DAC_SCLK; prev_din = bus.DAC_DIN;
    end
  end

  typedef struct {
    logic [N-1:0] yk;
    logic [15:0]  frame;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n, falls, band_before;
    logic busy_all, psclk;
    logic [N-1:0] y;

    vecs[0]  = '{25'h000ABC00, 16'h0ABC};
    vecs[1]  = '{25'h1FFFF00,  16'h0000};
    vecs[2]  = '{25'h0FFFFFF,  16'h0FFF};
    vecs[3]  = '{25'h0000000,  16'h0000};
    vecs[4]  = '{25'h00FFFFF,  16'h0FFF};
    vecs[5]  = '{25'h0100000,  16'h0FFF};
    vecs[6]  = '{25'h1000000,  16'h0000};
    vecs[7]  = '{25'h00000FF,  16'h0000};
    vecs[8]  = '{25'h0000100,  16'h0001};
    vecs[9]  = '{25'h0012345,  16'h0123};
    vecs[10] = '{25'h1FFFFFF,  16'h0000};
    vecs[11] = '{25'h00FFE80,  16'h0FFE};

    Reset_n = 1'b0;
    bus.Bandera_Listo = 1'b0;
    bus.Yk = '0;
    #3;
    chk_reset_outputs("reset");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // First-frame latency and Bandera_DAC timing.
    step(1'b1, 25'h000ABC00);
    chk("lat_sync_still_high", bus.DAC_SYNC_n, 1'b1);
    step(1'b0, '0);
    chk("lat_sync_fell", bus.DAC_SYNC_n, 1'b0);
    chk("lat_din_bit15", bus.DAC_DIN, 1'b0);
    chk("lat_sclk_high", bus.DAC_SCLK, 1'b1);
    n = 0;
    do begin
      step(1'b0, '0);
      n++;
    end while (!bus.Bandera_DAC && n < 200);
    chk("bandera_latency", n, 32 * DIV);
    wait_idle(200);
    if (got_q.size() > 0) chk("abc_frame", got_q[0], 16'h0ABC);
    check_frames();

    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].yk);
      wait_idle(200);
      chk("vec_frame_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("vec_frame", got_q[0], vecs[i].frame);
      check_frames();
    end

    // Strobes every 11 Clk: only the latest pending sample survives.
    busy_all = 1'b1;
    m_ow_cnt = 0;
    dut_ow_cnt = 0;
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, 25'(j * 256));
      busy_all &= bus.Ocupado;
      for (int k = 0; k < 10; k++) begin
        step(1'b0, '0);
        busy_all &= bus.Ocupado;
      end
    end
    chk("burst_ocupado", busy_all, 1'b1);
    wait_idle(400);
    chk("burst_ow_count", dut_ow_cnt, m_ow_cnt);
    if (got_q.size() > 0) chk("burst_first_code", got_q[0], 16'h0001);
    check_frames();

    // Strobes landing exactly on the consume edges.
    step(1'b1, 25'h0011100);
    step(1'b1, 25'h0022200);
    chk("consume_edge_ow_1", bus.Sobre_Escritura, 1'b0);
    for (int k = 0; k < 34 * DIV; k++) step(1'b0, '0);
    step(1'b1, 25'h0033300);
    chk("consume_edge_ow_2", bus.Sobre_Escritura, 1'b0);
    wait_idle(300);
    chk("consume_frame_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("consume_frame_a", got_q[0], 16'h0111);
      chk("consume_frame_b", got_q[1], 16'h0222);
      chk("consume_frame_c", got_q[2], 16'h0333);
    end
    check_frames();

    // Reset after the 7th SCLK fall aborts the frame.
    step(1'b1, 25'h0055500);
    falls = 0;
    n = 0;
    psclk = bus.DAC_SCLK;
    while (falls < 7 && n < 300) begin
      step(1'b0, '0);
      if (psclk && !bus.DAC_SCLK) falls++;
      psclk = bus.DAC_SCLK;
      n++;
    end
    chk("abort_reached_fall7", falls, 7);
    band_before = n_band;
    #1;
    Reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge Clk);
    @(negedge Clk);
    y = 25'h00ABC00;
    Reset_n = 1'b1;
    bus.Bandera_Listo = 1'b1;
    bus.Yk = y;
    m_pend_v = 1'b0;
    m_free_at = 0;
    exp_q.delete();
    chk("abort_no_frame", got_q.size(), 0);
    chk("abort_no_bandera", n_band, band_before);
    @(posedge Clk);
    model_edge(1'b1, y);
    #1;
    chk("post_reset_ocupado", bus.Ocupado, 1'b1);
    step(1'b0, '0);
    chk("post_reset_sync_fell", bus.DAC_SYNC_n, 1'b0);
    wait_idle(200);
    if (got_q.size() > 0) chk("post_reset_frame", got_q[0], 16'h0ABC);
    check_frames();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 2))
        0:       y = N'($urandom);
        1:       y = N'($urandom_range(0, 4096 * 256 + 512));
        default: y = N'(-$urandom_range(0, 2000));
      endcase
      step($urandom_range(0, 29) == 0, y);
    end
    wait_idle(400);
    check_frames();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_serializador.md
DAC_SERIALIZADOR -- requirements
Module: dac_serializador

Interface
REQ-001 SHALL have parameter N, default 25: width of the filter output word Yk (signed, two's complement).
REQ-002 SHALL have parameter SHIFT, default 8: arithmetic right shift that maps Yk onto the 12-bit DAC code.
REQ-003 SHALL have parameter DIV, default 2 (min 1): Clk cycles per DAC_SCLK half-period.
REQ-004 SHALL have port Clk, input, 1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port Yk, input, N: filter output sample.
REQ-007 SHALL have port Bandera_Listo, input, 1: one-cycle strobe, Yk valid.
REQ-008 SHALL have port DAC_SYNC_n, output, 1: DAC frame select, active-low.
REQ-009 SHALL have port DAC_SCLK, output, 1: DAC serial clock.
REQ-010 SHALL have port DAC_DIN, output, 1: DAC serial data, MSB first.
REQ-011 SHALL have port Ocupado, output, 1: high while a frame is active or a sample is pending.
REQ-012 SHALL have port Bandera_DAC, output, 1: one-cycle pulse at frame end.
REQ-013 SHALL have port Sobre_Escritura, output, 1: one-cycle pulse when a pending sample is overwritten.

Function
REQ-014 SHALL convert on capture: code = Yk >>> SHIFT (sign-preserving); code < 0 -> 0; code > 4095 -> 4095; else low 12 bits.
REQ-015 SHALL send a 16-bit frame {4'b0000, code[11:0]}, MSB first.
REQ-016 SHALL hold a one-deep pending buffer (Pend, Pend_v); a Clk edge with Bandera_Listo=1 writes the converted code to Pend and sets Pend_v.
REQ-017 SHALL use FSM states IDLE, SHIFT, GAP.
REQ-018 IDLE: DAC_SYNC_n=1, DAC_SCLK=1, DAC_DIN=0; on the edge after Pend_v=1, SHALL load shift register from Pend, clear Pend_v, enter SHIFT.
REQ-019 Latency: DAC_SYNC_n SHALL fall exactly one Clk after the capture edge when IDLE with Pend_v=0, with DAC_DIN=frame bit 15 and DAC_SCLK=1.
REQ-020 SHIFT: DAC_SCLK SHALL toggle every DIV Clk, starting with a fall DIV Clk after DAC_SYNC_n falls; DAC_DIN SHALL change only with DAC_SCLK rising, stable across each falling edge (DAC sample edge).
REQ-021 After the 16th falling edge plus DIV Clk, SHALL set DAC_SCLK=1, DAC_SYNC_n=1, pulse Bandera_DAC one cycle, enter GAP; frame length 32*DIV Clk.
REQ-022 GAP: SHALL hold DAC_SYNC_n=1 for 2*DIV Clk, then IDLE; a pending sample starts on the following edge.
REQ-023 Bandera_Listo while Pend_v=1 and Pend not consumed on that edge: SHALL overwrite Pend (newest wins) and pulse Sobre_Escritura one cycle.
REQ-024 Bandera_Listo on the same edge Pend is consumed: SHALL store the new sample, keep Pend_v=1, no Sobre_Escritura.
REQ-025 Bandera_Listo during SHIFT SHALL never alter the frame in progress.
REQ-026 Ocupado SHALL equal (state != IDLE) OR Pend_v.

Reset
REQ-027 Reset_n=0 SHALL immediately, independent of Clk: state IDLE, Pend_v=0, DAC_SYNC_n=1, DAC_SCLK=1, DAC_DIN=0, Ocupado=0, Bandera_DAC=0, Sobre_Escritura=0.
REQ-028 Reset mid-frame SHALL abort the frame (DAC_SYNC_n rises before 16 falling edges); no Bandera_DAC pulse for it.
REQ-029 After Reset_n rises, first Clk edge SHALL accept Bandera_Listo normally.

Verification
REQ-030 Yk=25'h000ABC00, one strobe, DIV=2 -> SYNC_n falls 1 Clk later; 16 bits 0000_1010_1011_1100 on SCLK falls; Bandera_DAC 64 Clk after SYNC_n falls.
REQ-031 Yk=25'h1FFFF00 (-256) -> frame 0x0000; Yk=25'h0FFFFFF -> frame 0x0FFF (saturation).
REQ-032 Strobe every 11 Clk with 0x100,0x200,0x300,... -> frames carry codes 0x001 then latest pending only; Sobre_Escritura pulses per overwritten sample; Ocupado continuously 1.
REQ-033 Strobe on exact edge Pend is consumed -> no Sobre_Escritura; both samples transmitted in order.
REQ-034 Reset_n low after 7th SCLK fall -> outputs at reset values within the same Clk; no Bandera_DAC; next strobe yields a full correct frame.
REQ-035 Monitor checks: DAC_DIN never changes at an SCLK fall; DAC_SYNC_n high >= 2*DIV Clk between frames.
